// File: rtl/jmb_window_ctrl_if.sv
// Stream/window handshake bundle for the 9x9 window controller.
// The slave modport faces the controller; the master modport faces the environment.
interface jmb_window_ctrl_if;
  logic        s_valid;
  logic        s_sof;
  logic        s_ready;
  logic        m_ready;
  logic        win_enable;
  logic        win_valid;
  logic [15:0] center_col;
  logic [15:0] center_row;
  logic        frame_busy;
  logic        frame_done;
  logic        sof_err;

  modport slave (
    input  s_valid, s_sof, m_ready,
    output s_ready, win_enable, win_valid,
    output center_col, center_row,
    output frame_busy, frame_done, sof_err
  );

  modport master (
    output s_valid, s_sof, m_ready,
    input  s_ready, win_enable, win_valid,
    input  center_col, center_row,
    input  frame_busy, frame_done, sof_err
  );
endinterface

// File: rtl/jmb_window_ctrl.sv
// Frame/raster controller for a 9x9 sliding-window datapath.
// Define JMB_WINDOW_CTRL_RESYNC_EN to restart the frame on a mid-frame s_sof.
module jmb_window_ctrl #(
  parameter int image_width  = 10,
  parameter int image_height = 10
) (
  input logic           clock,
  input logic           reset_n,
  jmb_window_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  localparam logic [15:0] LAST_COL = 16'(image_width - 1);
  localparam logic [15:0] LAST_ROW = 16'(image_height - 1);

  state_t      state_q, state_d;
  logic [15:0] col_q, row_q;
  logic [15:0] col_d, row_d;
  logic [15:0] pix_col, pix_row;
  logic        accept;
  logic        resync;
  logic        sof_hit;
  logic        win_en;
  logic        wv_d;
  logic        win_valid_q;
  logic        sof_err_q;
  logic [15:0] ccol_q, crow_q;

  assign bus.s_ready = reset_n && bus.m_ready
                     && (state_q != DONE);
  assign accept = bus.s_valid && bus.s_ready;

`ifdef JMB_WINDOW_CTRL_RESYNC_EN
  assign resync = bus.s_sof;
`else
  assign resync = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pix_col = col_q;
    pix_row = row_q;
    win_en  = 1'b0;
    sof_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && bus.s_sof) begin
          win_en  = 1'b1;
          pix_col = '0;
          pix_row = '0;
          col_d   = 16'd1;
          row_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          win_en = 1'b1;
          if (resync) begin
            // restart: this beat is pixel (0,0)
            sof_hit = 1'b1;
            pix_col = '0;
            pix_row = '0;
            col_d   = 16'd1;
            row_d   = '0;
          end else if (col_q != LAST_COL) begin
            col_d = col_q + 16'd1;
          end else if (row_q != LAST_ROW) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d   = '0;
            row_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wv_d = win_en && (pix_row >= 16'd8)
              && (pix_col >= 16'd8);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_valid_q <= 1'b0;
      sof_err_q   <= 1'b0;
      ccol_q      <= '0;
      crow_q      <= '0;
    end else begin
      win_valid_q <= wv_d;
      sof_err_q   <= sof_hit;
      if (wv_d) begin
        ccol_q <= pix_col - 16'd4;
        crow_q <= pix_row - 16'd4;
      end
    end
  end

  assign bus.win_enable = win_en;
  assign bus.win_valid  = win_valid_q;
  assign bus.center_col = ccol_q;
  assign bus.center_row = crow_q;
  assign bus.frame_busy = (state_q == ACTIVE);
  assign bus.frame_done = (state_q == DONE);
  assign bus.sof_err    = sof_err_q;

endmodule

// File: tb/tb_jmb_window_ctrl.sv
// Directed bench for jmb_window_ctrl on a 10x10 frame.
// Expected coordinates come from a small raster model in run_frame.
module tb_jmb_window_ctrl;

`ifdef JMB_WINDOW_CTRL_RESYNC_EN
  localparam bit RESYNC_ON = 1'b1;
`else
  localparam bit RESYNC_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  jmb_window_ctrl_if bus ();

  jmb_window_ctrl #(
    .image_width (10),
    .image_height(10)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b want=0", bus.s_ready); end
    checks++; if (bus.win_enable !== 1'b0) begin failures++; $display("FAIL rst_win_enable got=%b want=0", bus.win_enable); end
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL rst_win_valid got=%b want=0", bus.win_valid); end
    checks++; if (bus.frame_busy !== 1'b0) begin failures++; $display("FAIL rst_frame_busy got=%b want=0", bus.frame_busy); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b want=0", bus.frame_done); end
    checks++; if (bus.sof_err !== 1'b0) begin failures++; $display("FAIL rst_sof_err got=%b want=0", bus.sof_err); end
    checks++; if (bus.center_col !== 16'd0) begin failures++; $display("FAIL rst_center_col got=%0d want=0", bus.center_col); end
    checks++; if (bus.center_row !== 16'd0) begin failures++; $display("FAIL rst_center_row got=%0d want=0", bus.center_row); end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL post_rst_s_ready got=%b want=1", bus.s_ready); end
  endtask

  task automatic stall5();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b0;
    repeat (5) begin
      #1;
      checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL stall_s_ready got=%b want=0", bus.s_ready); end
      checks++; if (bus.win_enable !== 1'b0) begin failures++; $display("FAIL stall_win_enable got=%b want=0", bus.win_enable); end
      @(posedge clock); #1;
      checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL stall_win_valid got=%b want=0", bus.win_valid); end
      checks++; if (bus.frame_busy !== 1'b1) begin failures++; $display("FAIL stall_frame_busy got=%b want=1", bus.frame_busy); end
    end
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
  endtask

  // Streams one frame starting with s_sof; called at posedge+1.
  task automatic run_frame(input int stall_beat, input int resync_beat);
    int r, c, pr, pc, beats, pulses, first, exp_first;
    bit done, rs, exp_wv;
    r = 0; c = 0; beats = 0; pulses = 0; first = -1; done = 1'b0;
    while (!done && beats < 400) begin
      if (beats == stall_beat) stall5();
      bus.s_valid = 1'b1;
      bus.s_sof   = (beats == 0) || (beats == resync_beat);
      #1;
      checks++; if (bus.win_enable !== 1'b1) begin failures++; $display("FAIL beat%0d_win_enable got=%b want=1", beats, bus.win_enable); end
      rs = (beats == resync_beat) && RESYNC_ON;
      if (rs) begin pr = 0; pc = 0; end
      else begin pr = r; pc = c; end
      @(posedge clock); #1;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      exp_wv = (pr >= 8) && (pc >= 8);
      checks++; if (bus.win_valid !== exp_wv) begin failures++; $display("FAIL beat%0d_win_valid got=%b want=%b", beats, bus.win_valid, exp_wv); end
      if (exp_wv) begin
        pulses++;
        if (first < 0) first = beats;
        checks++; if (bus.center_row !== 16'(pr - 4)) begin failures++; $display("FAIL beat%0d_center_row got=%0d want=%0d", beats, bus.center_row, pr - 4); end
        checks++; if (bus.center_col !== 16'(pc - 4)) begin failures++; $display("FAIL beat%0d_center_col got=%0d want=%0d", beats, bus.center_col, pc - 4); end
      end
      checks++; if (bus.sof_err !== rs) begin failures++; $display("FAIL beat%0d_sof_err got=%b want=%b", beats, bus.sof_err, rs); end
      if (pr == 9 && pc == 9) done = 1'b1;
      else begin
        checks++; if (bus.frame_busy !== 1'b1) begin failures++; $display("FAIL beat%0d_frame_busy got=%b want=1", beats, bus.frame_busy); end
      end
      if (rs) begin r = 0; c = 1; end
      else if (c == 9) begin c = 0; r++; end
      else c++;
      beats++;
    end
    exp_first = (RESYNC_ON && resync_beat >= 0) ? resync_beat + 88 : 88;
    checks++; if (!done) begin failures++; $display("FAIL frame_timeout got=%0d beats want=end of frame", beats); end
    checks++; if (pulses != 4) begin failures++; $display("FAIL win_valid_pulses got=%0d want=4", pulses); end
    checks++; if (first != exp_first) begin failures++; $display("FAIL first_win_beat got=%0d want=%0d", first, exp_first); end
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL frame_done got=%b want=1", bus.frame_done); end
    checks++; if (bus.frame_busy !== 1'b0) begin failures++; $display("FAIL done_frame_busy got=%b want=0", bus.frame_busy); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL done_s_ready got=%b want=0", bus.s_ready); end
    @(posedge clock); #1;
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL idle_frame_done got=%b want=0", bus.frame_done); end
    checks++; if (bus.frame_busy !== 1'b0) begin failures++; $display("FAIL idle_frame_busy got=%b want=0", bus.frame_busy); end
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL idle_s_ready got=%b want=1", bus.s_ready); end
  endtask

  task automatic test_basic();
    run_frame(-1, -1);
  endtask

  task automatic test_idle_discard();
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = 1'b0;
      #1;
      checks++; if (bus.win_enable !== 1'b0) begin failures++; $display("FAIL discard%0d_win_enable got=%b want=0", i, bus.win_enable); end
      checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL discard%0d_s_ready got=%b want=1", i, bus.s_ready); end
      @(posedge clock); #1;
      checks++; if (bus.frame_busy !== 1'b0) begin failures++; $display("FAIL discard%0d_frame_busy got=%b want=0", i, bus.frame_busy); end
    end
    bus.s_valid = 1'b0;
    run_frame(-1, -1);
  endtask

  task automatic test_back_pressure();
    run_frame(87, -1);
  endtask

  task automatic test_reset_midframe();
    for (int b = 0; b < 53; b++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = (b == 0);
      @(posedge clock); #1;
    end
    bus.s_sof = 1'b0;
    checks++; if (bus.frame_busy !== 1'b1) begin failures++; $display("FAIL mid_frame_busy got=%b want=1", bus.frame_busy); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.frame_busy !== 1'b0) begin failures++; $display("FAIL async_frame_busy got=%b want=0", bus.frame_busy); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL async_s_ready got=%b want=0", bus.s_ready); end
    checks++; if (bus.win_enable !== 1'b0) begin failures++; $display("FAIL async_win_enable got=%b want=0", bus.win_enable); end
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL async_win_valid got=%b want=0", bus.win_valid); end
    checks++; if (bus.center_col !== 16'd0) begin failures++; $display("FAIL async_center_col got=%0d want=0", bus.center_col); end
    bus.s_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b0;
    #1;
    checks++; if (bus.win_enable !== 1'b0) begin failures++; $display("FAIL after_rst_win_enable got=%b want=0", bus.win_enable); end
    @(posedge clock); #1;
    bus.s_valid = 1'b0;
    run_frame(-1, -1);
  endtask

  task automatic test_resync();
    run_frame(-1, 62);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_idle_discard();
    test_back_pressure();
    test_reset_midframe();
    test_resync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jmb_window_ctrl.md
JMB_WINDOW_CTRL -- requirements
Module: jmb_window_ctrl

Interface
REQ-001 Parameter image_width, default 10, pixels per line; SHALL be >= 9.
REQ-002 Parameter image_height, default 10, lines per frame; SHALL be >= 9.
REQ-003 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port s_valid  input  1  upstream pixel beat present.
REQ-006 Port s_sof  input  1  start-of-frame marker, qualified by s_valid.
REQ-007 Port s_ready  output  1  controller accepts beat; accept = s_valid && s_ready.
REQ-008 Port m_ready  input  1  downstream can take a window result this cycle.
REQ-009 Port win_enable  output  1  shift enable to the 9x9 window datapath; combinational, equals accept of a frame pixel.
REQ-010 Port win_valid  output  1  registered pulse: the 9x9 window holds a complete neighbourhood.
REQ-011 Port center_col  output  16  column of the window centre pixel, valid with win_valid.
REQ-012 Port center_row  output  16  row of the window centre pixel, valid with win_valid.
REQ-013 Port frame_busy  output  1  high while in ACTIVE.
REQ-014 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-015 Port sof_err  output  1  one-cycle pulse on a mid-frame s_sof (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, ACTIVE and DONE.
REQ-017 s_ready SHALL equal m_ready in IDLE and ACTIVE, and 0 in DONE.
REQ-018 In IDLE, accepted beats with s_sof=0 SHALL be discarded with win_enable=0.
REQ-019 In IDLE, an accepted beat with s_sof=1 SHALL assert win_enable, be pixel (row 0, col 0), and move the FSM to ACTIVE.
REQ-020 Internal 16-bit col/row counters SHALL hold the coordinates of the next pixel; col wraps image_width-1 -> 0 and increments row.
REQ-021 In ACTIVE, every accept SHALL assert win_enable and advance the counters.
REQ-022 Accept of pixel (image_height-1, image_width-1) SHALL move the FSM to DONE, and counters SHALL clear to 0.
REQ-023 DONE SHALL last exactly one cycle with frame_done=1, then return to IDLE.
REQ-024 win_valid SHALL be 1 in the cycle after accepting pixel (r,c) with r>=8 and c>=8, else 0; latency exactly 1 cycle.
REQ-025 With win_valid, center_row SHALL be r-4 and center_col SHALL be c-4; both hold their last value otherwise.
REQ-026 With m_ready=0, no beat SHALL be accepted, and counters, FSM and window contents SHALL be frozen.
REQ-027 s_sof=1 on an accepted beat in ACTIVE SHALL be handled per REQ-033/REQ-034.

Reset
REQ-028 reset_n low SHALL immediately force the FSM to IDLE and counters to 0, independent of clock.
REQ-029 During reset, win_valid, frame_done, sof_err and frame_busy SHALL be 0, and center_col/center_row SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next frame SHALL start only on a new s_sof beat.
REQ-031 win_enable and s_ready SHALL be 0 while reset_n is low.

Configuration
REQ-032 The macro JMB_WINDOW_CTRL_RESYNC_EN SHALL select the mid-frame s_sof behaviour.
REQ-033 With JMB_WINDOW_CTRL_RESYNC_EN defined, an accepted s_sof=1 beat in ACTIVE SHALL pulse sof_err, be taken as pixel (0,0), and leave the FSM in ACTIVE with counters at the (0,1) position.
REQ-034 Without JMB_WINDOW_CTRL_RESYNC_EN, s_sof in ACTIVE SHALL be ignored (beat treated as a normal pixel), and sof_err SHALL be tied 0.

Verification
REQ-035 10x10 frame, s_valid=1 and m_ready=1 throughout, s_sof on beat 0 -> first win_valid the cycle after beat 88 with centre (4,4); exactly 4 win_valid pulses with centres (4,4), (4,5), (5,4), (5,5); frame_done one cycle after beat 99; FSM returns to IDLE.
REQ-036 3 beats with s_sof=0 before the s_sof beat -> win_enable=0 for those 3 beats; frame counting starts at the s_sof beat.
REQ-037 m_ready low for 5 cycles at pixel (8,7) -> s_ready=0 and win_enable=0 for those cycles, counters frozen; after release, the next win_valid has centre (4,4).
REQ-038 reset_n pulsed low at pixel (5,3) -> all outputs 0 asynchronously; a subsequent full frame gives the same result as REQ-035.
REQ-039 With JMB_WINDOW_CTRL_RESYNC_EN, s_sof at pixel (6,2) -> sof_err pulse, restart at (0,0), 4 win_valid pulses before frame_done; without the macro -> sof_err=0, frame ends normally after beat 99.
